// File: rtl/ball_path_if.sv
// Game-side bundle of the ball chain engine: shot/frame controls towards the
// engine and the per-slot sprite data plus status flags coming back.
interface ball_path_if #(
  parameter int MAX_BALLS = 26
);
  logic       frame_clk;
  logic [1:0] Game_State;
  logic [1:0] random_color;
  logic [3:0] Color_in;
  logic [9:0] Shooted_pos_X;
  logic [9:0] Shooted_pos_Y;
  logic [9:0] Path_X   [MAX_BALLS-1:0];
  logic [9:0] Path_Y   [MAX_BALLS-1:0];
  logic [3:0] Path_Idx [MAX_BALLS-1:0];
  logic       inserted;
  logic [15:0] score;
  logic       dead;
  logic       win;

  modport master (
    output frame_clk, Game_State, random_color, Color_in, Shooted_pos_X, Shooted_pos_Y,
    input  Path_X, Path_Y, Path_Idx, inserted, score, dead, win
  );

  modport slave (
    input  frame_clk, Game_State, random_color, Color_in, Shooted_pos_X, Shooted_pos_Y,
    output Path_X, Path_Y, Path_Idx, inserted, score, dead, win
  );
endinterface

// File: rtl/ball_path.sv
// Zuma-style ball chain engine: advances the chain once per frame, inserts a
// colliding shot ball, removes one run of 3+ same-colour balls, tracks score/dead/win.
module ball_path #(
  parameter int MAX_BALLS  = 26,
  parameter int INIT_BALLS = 20,
  parameter int SPACING    = 16,
  parameter int PATH_END   = 999,
  parameter int POINTS     = 10
) (
  input logic        Clk,
  input logic        Reset,
  ball_path_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_MOVE, S_CHECK, S_INSERT, S_MATCH, S_REMOVE, S_HALT
  } state_t;

  state_t      r_state;
  logic [10:0] r_head;
  logic [5:0]  r_count;
  logic [3:0]  r_idx [MAX_BALLS];
  logic [4:0]  r_ins_pos;
  logic [3:0]  r_color;
  logic [4:0]  r_run_start;
  logic [5:0]  r_run_len;
  logic [15:0] r_score;
  logic        r_dead;
  logic        r_win;
  logic        r_inserted;
  logic        r_frame_s1;
  logic        r_frame_s2;

  logic [10:0] w_p [MAX_BALLS];
  logic [9:0]  w_x [MAX_BALLS];
  logic [9:0]  w_y [MAX_BALLS];
  logic        w_hit_found;
  logic [4:0]  w_hit_idx;
  logic [MAX_BALLS-1:0] w_match;
  logic [4:0]  w_run_start;
  logic [5:0]  w_run_end;
  logic [5:0]  w_run_len;
  logic [6:0]  w_src [MAX_BALLS];
  logic [3:0]  w_removed [MAX_BALLS];
  logic [16:0] w_score_sum;
  logic [5:0]  w_count_left;
  logic        w_frame_rise;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign w_frame_rise = r_frame_s1 & ~r_frame_s2;
  assign w_run_len    = w_run_end - {1'b0, w_run_start};
  assign w_score_sum  = {1'b0, r_score} + (17'(r_run_len) * 17'(POINTS));
  assign w_count_left = r_count - r_run_len;

  // Slot centres: horizontal leg up to distance 600, then down the right edge.
  always_comb begin
    for (int i = 0; i < MAX_BALLS; i++) begin
      w_p[i] = r_head - 11'(i * SPACING);
      if (6'(i) >= r_count) begin
        w_x[i] = 10'd0;
        w_y[i] = 10'd0;
      end else if (w_p[i] < 11'd600) begin
        w_x[i] = 10'(w_p[i] + 11'd20);
        w_y[i] = 10'd40;
      end else begin
        w_x[i] = 10'd619;
        w_y[i] = 10'(w_p[i] - 11'd560);
      end
    end
  end

  // Lowest occupied slot inside the collision window of the shot ball.
  always_comb begin
    w_hit_found = 1'b0;
    w_hit_idx   = 5'd0;
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      if ((6'(i) < r_count) &&
          (abs_diff(bus.Shooted_pos_X, w_x[i]) < 10'(SPACING)) &&
          (abs_diff(bus.Shooted_pos_Y, w_y[i]) < 10'(SPACING))) begin
        w_hit_found = 1'b1;
        w_hit_idx   = 5'(i);
      end else begin
        w_hit_found = w_hit_found;
      end
    end
  end

  // Bounds of the same-colour run around the inserted slot, plus the shifted-up chain.
  always_comb begin
    w_run_start = 5'd0;
    w_run_end   = 6'(MAX_BALLS);
    for (int i = 0; i < MAX_BALLS; i++) begin
      w_match[i]  = (6'(i) < r_count) && (r_idx[i] == r_color);
      w_run_start = ((5'(i) <= r_ins_pos) && !w_match[i]) ? 5'(i + 1) : w_run_start;
    end
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      w_run_end = ((5'(i) >= r_ins_pos) && !w_match[i]) ? 6'(i) : w_run_end;
    end
    for (int j = 0; j < MAX_BALLS; j++) begin
      w_src[j]     = 7'(j) + {1'b0, r_run_len};
      w_removed[j] = (w_src[j] < 7'(MAX_BALLS)) ? r_idx[w_src[j][4:0]] : 4'd0;
    end
  end

  // Output mapping towards the renderer and game FSM.
  always_comb begin
    for (int i = 0; i < MAX_BALLS; i++) begin
      bus.Path_X[i]   = w_x[i];
      bus.Path_Y[i]   = w_y[i];
      bus.Path_Idx[i] = (6'(i) < r_count) ? r_idx[i] : 4'd0;
    end
    bus.inserted = r_inserted;
    bus.score    = r_score;
    bus.dead     = r_dead;
    bus.win      = r_win;
  end

  // Chain engine FSM with frame-edge detection.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_INIT;
      r_head      <= 11'd0;
      r_count     <= 6'd0;
      r_ins_pos   <= 5'd0;
      r_color     <= 4'd0;
      r_run_start <= 5'd0;
      r_run_len   <= 6'd0;
      r_score     <= 16'd0;
      r_dead      <= 1'b0;
      r_win       <= 1'b0;
      r_inserted  <= 1'b0;
      r_frame_s1  <= 1'b0;
      r_frame_s2  <= 1'b0;
      for (int j = 0; j < MAX_BALLS; j++) r_idx[j] <= 4'd0;
    end else begin
      r_frame_s1 <= bus.frame_clk;
      r_frame_s2 <= r_frame_s1;
      r_inserted <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_idx[r_count[4:0]] <= {2'b00, bus.random_color} + 4'd1;
          r_count             <= r_count + 6'd1;
          if (r_count == 6'(INIT_BALLS - 1)) begin
            r_head  <= 11'((INIT_BALLS - 1) * SPACING);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_frame_rise && (bus.Game_State == 2'b01)) r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_head <= r_head + 11'd1;
          if ((r_head + 11'd1) >= 11'(PATH_END)) begin
            r_dead  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((bus.Color_in == 4'd0) || (r_count == 6'(MAX_BALLS))) begin
            r_state <= S_WAIT;
          end else if (w_hit_found) begin
            r_ins_pos  <= w_hit_idx;
            r_color    <= bus.Color_in;
            r_inserted <= 1'b1;
            r_state    <= S_INSERT;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_INSERT: begin
          for (int j = 1; j < MAX_BALLS; j++) begin
            if ((5'(j) > r_ins_pos) && (6'(j) <= r_count)) r_idx[j] <= r_idx[j-1];
          end
          r_idx[r_ins_pos] <= r_color;
          r_count          <= r_count + 6'd1;
          r_head           <= r_head + 11'(SPACING);
          r_state          <= S_MATCH;
        end
        S_MATCH: begin
          r_run_start <= w_run_start;
          r_run_len   <= w_run_len;
          r_state     <= (w_run_len >= 6'd3) ? S_REMOVE : S_WAIT;
        end
        S_REMOVE: begin
          for (int j = 0; j < MAX_BALLS; j++) begin
            if (5'(j) >= r_run_start) r_idx[j] <= w_removed[j];
          end
          r_count <= w_count_left;
          r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
          if (w_count_left == 6'd0) begin
            r_win   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_path.sv
// Bench for ball_path: directed scenarios plus random frames against a queue-based chain model.
module tb_ball_path;
  localparam int MAXB = 26;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ball_path_if #(.MAX_BALLS(MAXB)) bus ();
  ball_path dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  // Reference chain model: colours in track order, lead distance, status.
  int m_col[$];
  int m_head;
  int m_score;
  bit m_dead;
  bit m_win;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void slot_pos(input int head, input int i, output int x, output int y);
    int p;
    p = head - 16 * i;
    if (p < 600) begin x = 20 + p; y = 40; end
    else begin x = 619; y = 40 + p - 600; end
  endfunction

  function automatic int occupied();
    int n;
    n = 0;
    for (int i = 0; i < MAXB; i++) if (bus.Path_Idx[i] != 4'd0) n++;
    return n;
  endfunction

  task automatic model_frame(input int gs, input int col, input int sx, input int sy, output int eins);
    int hit, x, y, s, e, n;
    eins = 0;
    if (m_dead || m_win || gs != 1) return;
    m_head++;
    if (m_head >= 999) begin m_dead = 1; return; end
    if (col == 0 || m_col.size() == MAXB) return;
    hit = -1;
    for (int i = 0; i < m_col.size(); i++) begin
      slot_pos(m_head, i, x, y);
      if (hit < 0 && iabs(sx - x) < 16 && iabs(sy - y) < 16) hit = i;
    end
    if (hit < 0) return;
    eins = 1;
    m_col.insert(hit, col);
    m_head += 16;
    s = hit;
    while (s > 0 && m_col[s-1] == col) s--;
    e = hit;
    while (e + 1 < m_col.size() && m_col[e+1] == col) e++;
    n = e - s + 1;
    if (n >= 3) begin
      for (int k = 0; k < n; k++) m_col.delete(s);
      m_score += 10 * n;
      if (m_score > 65535) m_score = 65535;
      if (m_col.size() == 0) m_win = 1;
    end
  endtask

  // fixed_col < 0 loads random colours, otherwise that random_color value every clock.
  task automatic do_reset(input int fixed_col);
    int c;
    bus.frame_clk = 1'b0; bus.Color_in = 4'd0; bus.Game_State = 2'd1;
    bus.Shooted_pos_X = 10'd0; bus.Shooted_pos_Y = 10'd0; bus.random_color = 2'd0;
    Reset = 1'b0;
    m_col.delete(); m_head = 304; m_score = 0; m_dead = 0; m_win = 0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      c = (fixed_col < 0) ? int'($urandom_range(0, 3)) : fixed_col;
      bus.random_color = 2'(c);
      m_col.push_back(c + 1);
      @(negedge Clk);
    end
  endtask

  task automatic do_frame(input int gs, input int col, input int sx, input int sy,
                          output int nins, output int eins);
    bus.Game_State = 2'(gs); bus.Color_in = 4'(col);
    bus.Shooted_pos_X = 10'(sx); bus.Shooted_pos_Y = 10'(sy);
    bus.frame_clk = 1'b1;
    nins = 0;
    repeat (3) begin @(negedge Clk); if (bus.inserted === 1'b1) nins++; end
    bus.frame_clk = 1'b0;
    repeat (12) begin @(negedge Clk); if (bus.inserted === 1'b1) nins++; end
    bus.Color_in = 4'd0; bus.Game_State = 2'd1;
    model_frame(gs, col, sx, sy, eins);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1;
    checks++; if (bus.score !== 16'd0 || bus.dead !== 1'b0 || bus.win !== 1'b0 || bus.inserted !== 1'b0) begin
      errors++; $display("FAIL reset_status: got score=%0d dead=%0b win=%0b ins=%0b want 0", bus.score, bus.dead, bus.win, bus.inserted); end
    checks++; if (bus.Path_Idx[0] !== 4'd0 || bus.Path_X[0] !== 10'd0) begin
      errors++; $display("FAIL reset_slot0: got idx=%0d x=%0d want 0", bus.Path_Idx[0], bus.Path_X[0]); end
    do_reset(1);
    checks++; if (occupied() != 20) begin errors++; $display("FAIL load_count: got %0d want 20", occupied()); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.Path_Idx[i] !== 4'd2) begin errors++; $display("FAIL load_idx%0d: got %0d want 2", i, bus.Path_Idx[i]); end
    end
    checks++; if (bus.Path_X[0] !== 10'd324 || bus.Path_Y[0] !== 10'd40) begin
      errors++; $display("FAIL load_slot0: got (%0d,%0d) want (324,40)", bus.Path_X[0], bus.Path_Y[0]); end
    checks++; if (bus.Path_X[19] !== 10'd20 || bus.Path_Y[19] !== 10'd40) begin
      errors++; $display("FAIL load_slot19: got (%0d,%0d) want (20,40)", bus.Path_X[19], bus.Path_Y[19]); end
    for (int i = 20; i < MAXB; i++) begin
      checks++; if (bus.Path_X[i] !== 10'd0 || bus.Path_Y[i] !== 10'd0 || bus.Path_Idx[i] !== 4'd0) begin
        errors++; $display("FAIL load_empty%0d: got (%0d,%0d,%0d) want 0", i, bus.Path_X[i], bus.Path_Y[i], bus.Path_Idx[i]); end
    end
  endtask

  task automatic test_miss();
    int n, e;
    do_reset(1);
    do_frame(1, 2, 281, 400, n, e);
    checks++; if (n != 0) begin errors++; $display("FAIL miss_inserted: got %0d want 0", n); end
    checks++; if (bus.Path_X[0] !== 10'd325) begin errors++; $display("FAIL miss_x0: got %0d want 325", bus.Path_X[0]); end
    checks++; if (bus.score !== 16'd0 || occupied() != 20) begin
      errors++; $display("FAIL miss_state: got score=%0d count=%0d want 0/20", bus.score, occupied()); end
  endtask

  task automatic test_insert();
    int n, e;
    do_reset(0);
    do_frame(1, 3, 101, 40, n, e);
    checks++; if (n != 1) begin errors++; $display("FAIL ins_pulse: got %0d want 1", n); end
    checks++; if (occupied() != 21) begin errors++; $display("FAIL ins_count: got %0d want 21", occupied()); end
    checks++; if (bus.Path_Idx[14] !== 4'd3 || bus.Path_X[14] !== 10'd117) begin
      errors++; $display("FAIL ins_slot14: got idx=%0d x=%0d want 3/117", bus.Path_Idx[14], bus.Path_X[14]); end
    checks++; if (bus.Path_X[0] !== 10'd341) begin errors++; $display("FAIL ins_head: got x0=%0d want 341", bus.Path_X[0]); end
    checks++; if (bus.Path_Idx[13] !== 4'd1 || bus.Path_Idx[15] !== 4'd1 || bus.score !== 16'd0) begin
      errors++; $display("FAIL ins_nbr: got %0d/%0d score=%0d want 1/1/0", bus.Path_Idx[13], bus.Path_Idx[15], bus.score); end
  endtask

  task automatic test_win();
    int n, e;
    do_reset(1);
    do_frame(1, 2, 101, 40, n, e);
    checks++; if (n != 1) begin errors++; $display("FAIL win_pulse: got %0d want 1", n); end
    checks++; if (bus.score !== 16'd210) begin errors++; $display("FAIL win_score: got %0d want 210", bus.score); end
    checks++; if (bus.win !== 1'b1 || bus.dead !== 1'b0) begin
      errors++; $display("FAIL win_flags: got win=%0b dead=%0b want 1/0", bus.win, bus.dead); end
    checks++; if (occupied() != 0 || bus.Path_X[0] !== 10'd0) begin
      errors++; $display("FAIL win_empty: got count=%0d x0=%0d want 0", occupied(), bus.Path_X[0]); end
    do_frame(1, 2, 101, 40, n, e);
    checks++; if (n != 0 || bus.score !== 16'd210 || bus.win !== 1'b1 || occupied() != 0) begin
      errors++; $display("FAIL win_frozen: got ins=%0d score=%0d win=%0b want 0/210/1", n, bus.score, bus.win); end
  endtask

  task automatic test_dead();
    int n, e;
    do_reset(0);
    for (int k = 0; k < 694; k++) do_frame(1, 0, 0, 0, n, e);
    checks++; if (bus.dead !== 1'b0 || bus.Path_X[0] !== 10'd619 || bus.Path_Y[0] !== 10'd438) begin
      errors++; $display("FAIL dead_early: got dead=%0b (%0d,%0d) want 0 (619,438)", bus.dead, bus.Path_X[0], bus.Path_Y[0]); end
    do_frame(1, 0, 0, 0, n, e);
    checks++; if (bus.dead !== 1'b1 || bus.win !== 1'b0) begin
      errors++; $display("FAIL dead_flag: got dead=%0b win=%0b want 1/0", bus.dead, bus.win); end
    checks++; if (bus.Path_Y[0] !== 10'd439) begin errors++; $display("FAIL dead_y0: got %0d want 439", bus.Path_Y[0]); end
    do_frame(1, 2, 619, 439, n, e);
    checks++; if (n != 0 || bus.Path_Y[0] !== 10'd439 || bus.dead !== 1'b1 || occupied() != 20) begin
      errors++; $display("FAIL dead_frozen: got ins=%0d y0=%0d dead=%0b want 0/439/1", n, bus.Path_Y[0], bus.dead); end
  endtask

  task automatic test_full();
    int n, e, tx, ty;
    do_reset(0);
    for (int k = 0; k < 6; k++) begin
      slot_pos(m_head + 1, 0, tx, ty);
      do_frame(1, (k % 2 == 0) ? 2 : 3, tx, ty, n, e);
      checks++; if (n != 1) begin errors++; $display("FAIL full_fill%0d: got ins=%0d want 1", k, n); end
    end
    checks++; if (occupied() != 26 || bus.Path_Idx[0] !== 4'd3 || bus.Path_Idx[1] !== 4'd2) begin
      errors++; $display("FAIL full_count: got %0d idx0=%0d idx1=%0d want 26/3/2", occupied(), bus.Path_Idx[0], bus.Path_Idx[1]); end
    do_frame(1, 2, 427, 40, n, e);
    checks++; if (n != 0 || occupied() != 26) begin
      errors++; $display("FAIL full_noins: got ins=%0d count=%0d want 0/26", n, occupied()); end
    checks++; if (bus.Path_X[0] !== 10'd427) begin errors++; $display("FAIL full_head: got %0d want 427", bus.Path_X[0]); end
    do_frame(0, 0, 0, 0, n, e);
    checks++; if (bus.Path_X[0] !== 10'd427) begin errors++; $display("FAIL pause_head: got %0d want 427", bus.Path_X[0]); end
  endtask

  task automatic test_random();
    int n, e, gs, col, tx, ty, sx, sy, ex, ey, ec;
    for (int run = 0; run < 3; run++) begin
      do_reset(-1);
      for (int f = 0; f < 150; f++) begin
        gs  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 1;
        col = int'($urandom_range(0, 4));
        if (m_col.size() > 0 && $urandom_range(0, 3) != 0) begin
          slot_pos(m_head + 1, int'($urandom_range(0, m_col.size() - 1)), tx, ty);
          sx = tx + int'($urandom_range(0, 30)) - 15;
          sy = ty + int'($urandom_range(0, 30)) - 15;
          if (sx < 0) sx = 0;
          if (sy < 0) sy = 0;
        end else begin
          sx = int'($urandom_range(0, 1023));
          sy = int'($urandom_range(0, 1023));
        end
        do_frame(gs, col, sx, sy, n, e);
        checks++; if (n != e || bus.score !== 16'(m_score) || bus.dead !== m_dead || bus.win !== m_win) begin
          errors++; $display("FAIL rand_status: got ins=%0d score=%0d dead=%0b win=%0b want %0d/%0d/%0b/%0b",
                             n, bus.score, bus.dead, bus.win, e, m_score, m_dead, m_win); end
        for (int i = 0; i < MAXB; i++) begin
          if (i < m_col.size()) begin slot_pos(m_head, i, ex, ey); ec = m_col[i]; end
          else begin ex = 0; ey = 0; ec = 0; end
          checks++; if (bus.Path_X[i] !== 10'(ex) || bus.Path_Y[i] !== 10'(ey) || bus.Path_Idx[i] !== 4'(ec)) begin
            errors++; $display("FAIL rand_slot%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                               i, bus.Path_X[i], bus.Path_Y[i], bus.Path_Idx[i], ex, ey, ec); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_insert();
    test_win();
    test_dead();
    test_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ball_path.md
Name: ball_path

Overview:
- Zuma-style ball chain engine.
- Holds up to 26 coloured balls on a fixed two-segment track and advances the chain once per video frame.
- Inserts a shot ball when it collides with the chain, removes runs of 3 or more same-colour balls, and reports score, dead and win.
- Sits between the game FSM/shooter logic and the sprite renderer.

Parameters:
- MAX_BALLS, 26, slot count (fixed array size of the Path_* ports).
- INIT_BALLS, 20, balls loaded after reset.
- SPACING, 16, track distance between adjacent balls; also the collision half-window.
- PATH_END, 999, track distance at which the lead ball kills the player.
- POINTS, 10, score per removed ball.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vertical-sync-rate strobe; its rising edge is detected in the Clk domain.
- Game_State  in  2  2'b01 = PLAY; any other value freezes motion and shots.
- random_color  in  2  LFSR value; the colour of a loaded ball is random_color+1.
- Color_in  in  4  shot ball colour; 0 = no shot pending.
- Shooted_pos_X  in  10  shot ball centre X.
- Shooted_pos_Y  in  10  shot ball centre Y.
- Path_X[25:0]  out  10 each  slot centre X; 0 if the slot is empty.
- Path_Y[25:0]  out  10 each  slot centre Y; 0 if the slot is empty.
- Path_Idx[25:0]  out  4 each  slot colour; 0 = empty.
- inserted  out  1  one-Clk pulse when a shot is inserted.
- score  out  16  accumulated score.
- dead  out  1  sticky; lead ball reached PATH_END.
- win  out  1  sticky; chain emptied by a removal.

Behaviour:
- State: Head (11-bit track distance of slot 0, the lead ball); Counter (6-bit ball count); slots 0..Counter-1 are occupied and contiguous.
- Slot position: p_i = Head − i·SPACING. If p < 600: X = 20+p, Y = 40. Otherwise X = 619, Y = 40+(p−600). Slots ≥ Counter output X=Y=Idx=0.
- Reset (async, Reset=0): Head=0, Counter=0, all Idx=0, score=0, dead=0, win=0, inserted=0, FSM=INIT.
- FSM states: INIT, WAIT, MOVE, CHECK, INSERT, MATCH, REMOVE, HALT.
- INIT: on each Clk, load slot Counter with colour random_color+1 and increment Counter. After INIT_BALLS clocks, set Head = (INIT_BALLS−1)·SPACING = 304 and go to WAIT.
- WAIT: on a frame_clk rising edge with Game_State = PLAY, go to MOVE; otherwise stay.
- MOVE: Head += 1. If Head ≥ PATH_END, set dead=1 and go to HALT; else go to CHECK.
- CHECK:
  - If Color_in = 0 or Counter = MAX_BALLS, go to WAIT.
  - Otherwise find the lowest i < Counter with |Shooted_pos_X − X_i| < SPACING and |Shooted_pos_Y − Y_i| < SPACING.
  - If found, latch calculated_index = i and go to INSERT; else go to WAIT.
- INSERT (1 clk):
  - Shift slots i..Counter−1 to i+1..Counter; slot i = Color_in.
  - Counter += 1; Head += SPACING (the lead is pushed forward).
  - Pulse inserted = 1 for this clock; go to MATCH.
- MATCH (1 clk): compute the maximal run of Color_in containing slot i (start s, length n). If n ≥ 3, go to REMOVE; else go to WAIT.
- REMOVE (1 clk):
  - Shift slots s+n.. up by n and clear the vacated tail slots; Counter −= n.
  - score += n·POINTS, saturating at 16'hFFFF. Head is unchanged.
  - If Counter becomes 0, set win=1 and go to HALT; else go to WAIT.
  - Only one removal pass per insertion; no chain reactions.
- HALT: hold all state until reset.
- At most one insertion per frame.
- The shooter clears Color_in after seeing inserted; the same Color_in/position held across frames inserts again on each frame.
- Frame edges arriving during CHECK..REMOVE are dropped.
- dead and win are never both set.
- Reset mid-operation returns the block to INIT immediately.

Test Plan:
- Reset low then high, random_color = 1 held, Game_State = 1, no frame edges → after 20 clk: Counter = 20, all Idx = 2; slot0 at (324,40); slot19 at (20,40); slots 20..25 are 0.
- One frame edge with Color_in = 2 and shot at (281,400) → Head = 305, slot0 X = 325, no inserted pulse, score = 0.
- random_color = 0 (colour 1); one frame edge with Color_in = 3 and shot at (101,40) → hit slot 14; inserted pulses once; Counter = 21; Head = 321; slot14 Idx = 3 at X = 117; score = 0.
- random_color = 1; one frame edge with Color_in = 2 and shot at (101,40) → insert at 14, run n = 21 removed; Counter = 0; score = 210; win = 1; outputs stay frozen on later frames.
- No shots (Color_in = 0), 695 frame edges → dead = 1 after the 695th edge (Head = 999); further frames change nothing.
- Counter = 26 (fill by repeated non-matching inserts), then a colliding shot → no insertion and no inserted pulse; Counter stays 26. Then Game_State = 0 with a frame edge → Head unchanged.
